// File: rtl/axis_arb_pkg.sv
// Shared types and default sizes for the AXI4-Stream round-robin arbiter.
package axis_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = $clog2(NUM_SRC);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request at or after rr_ptr.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          sel_valid,
    output logic [IW-1:0] sel_idx
);

    function automatic logic [IW-1:0] wrap_idx(
        input logic [IW-1:0] base,
        input int            off
    );
        int j;
        j = int'(base) + off;
        if (j >= N) begin
            j = j - N;
        end
        return IW'(j);
    endfunction

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                sel_valid = 1'b1;
                sel_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream N:1 arbiter with a single registered output beat.
module axis_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [ID_W-1:0]           m_axis_tid,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      monitor_tvalid,
    output logic                      monitor_tready
);

    import axis_arb_pkg::*;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] cand;
    logic              sel_valid;
    logic [ID_W-1:0]   sel_idx;
    logic              load_en;
    logic              accept;
    logic [ID_W-1:0]   ptr_next;
    logic [DATA_W-1:0] sel_data;

    assign cand    = s_axis_tvalid & src_enable;
    assign load_en = (state == EMPTY) || m_axis_tready;
    assign accept  = load_en && sel_valid;

    rr_picker #(
        .N  (NUM_SRC),
        .IW (ID_W)
    ) u_picker (
        .req       (cand),
        .rr_ptr    (rr_ptr),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    assign sel_data = s_axis_tdata[sel_idx*DATA_W +: DATA_W];
    assign ptr_next = (sel_idx == ID_W'(NUM_SRC - 1)) ? '0 : sel_idx + 1'b1;

    // Held low during reset so no source believes a beat was taken.
    always_comb begin
        s_axis_tready = '0;
        if (accept && !reset) begin
            s_axis_tready[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            rr_ptr       <= '0;
            m_axis_tdata <= '0;
            m_axis_tid   <= '0;
        end else if (accept) begin
            state        <= FULL;
            rr_ptr       <= ptr_next;
            m_axis_tdata <= sel_data;
            m_axis_tid   <= sel_idx;
        end else if (state == FULL && m_axis_tready) begin
            state <= EMPTY;
        end
    end

    assign m_axis_tvalid  = (state == FULL);
    assign monitor_tvalid = m_axis_tvalid;
    assign monitor_tready = m_axis_tready;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed and randomised self-checking bench for axis_rr_arbiter.
module tb_axis_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]   s_axis_tvalid;
    logic [NS-1:0]   s_axis_tready;
    logic [NS-1:0]   src_enable;
    logic [DW-1:0]   m_axis_tdata;
    logic [1:0]      m_axis_tid;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            monitor_tvalid;
    logic            monitor_tready;

    int tests = 0;
    int fails = 0;

    axis_rr_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .src_enable     (src_enable),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .monitor_tvalid (monitor_tvalid),
        .monitor_tready (monitor_tready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        src_enable    = 4'hF;
        s_axis_tvalid = 4'hF;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NS; i++) s_axis_tdata[i*DW +: DW] = 32'hA0 + i;
        tick;
        tick;
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid);
        end
        tests++;
        if (m_axis_tdata !== 32'h0) begin
            fails++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata);
        end
        tests++;
        if (m_axis_tid !== 2'd0) begin
            fails++; $display("FAIL reset_tid got %0d want 0", m_axis_tid);
        end
        tests++;
        if (dut.rr_ptr !== 2'd0) begin
            fails++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr);
        end
        @(negedge clk);
        tests++;
        if (s_axis_tready !== 4'b0000) begin
            fails++; $display("FAIL reset_tready got %b want 0000", s_axis_tready);
        end
        tick;
        reset         = 1'b0;
        s_axis_tvalid = 4'h0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp4;
        s_axis_tvalid = 4'hF;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp4 = 4'b0001 << (k % 4);
            @(negedge clk);
            tests++;
            if (s_axis_tready !== exp4) begin
                fails++; $display("FAIL rr_tready k=%0d got %b want %b", k, s_axis_tready, exp4);
            end
            tick;
            tests++;
            if ({m_axis_tvalid, m_axis_tid, m_axis_tdata} !== {1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4)}) begin
                fails++;
                $display("FAIL rr_out k=%0d got v=%0b id=%0d d=%h want v=1 id=%0d d=%h",
                         k, m_axis_tvalid, m_axis_tid, m_axis_tdata, k % 4, 32'hA0 + 32'(k % 4));
            end
        end
        s_axis_tvalid = 4'h0;
        tick;
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++; $display("FAIL rr_drain got tvalid=%0b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_backpressure;
        s_axis_tvalid = 4'b0100;
        s_axis_tdata[2*DW +: DW] = 32'h1234;
        m_axis_tready = 1'b0;
        @(negedge clk);
        tests++;
        if (s_axis_tready !== 4'b0100) begin
            fails++; $display("FAIL bp_first_tready got %b want 0100", s_axis_tready);
        end
        tick;
        s_axis_tdata[2*DW +: DW] = 32'h5678;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready} !== {1'b1, 2'd2, 32'h1234, 4'b0000}) begin
                fails++;
                $display("FAIL bp_hold k=%0d got v=%0b id=%0d d=%h rdy=%b want v=1 id=2 d=1234 rdy=0000",
                         k, m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready);
            end
            tick;
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        tests++;
        if ({monitor_tvalid && monitor_tready, s_axis_tready} !== {1'b1, 4'b0100}) begin
            fails++;
            $display("FAIL bp_release got hs=%0b rdy=%b want hs=1 rdy=0100",
                     monitor_tvalid && monitor_tready, s_axis_tready);
        end
        tick;
        s_axis_tvalid = 4'h0;
        tests++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'h5678}) begin
            fails++; $display("FAIL bp_next got v=%0b d=%h want v=1 d=5678", m_axis_tvalid, m_axis_tdata);
        end
        tick;
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++; $display("FAIL bp_drain got tvalid=%0b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_enable_mask;
        s_axis_tvalid = 4'b1010;
        src_enable    = 4'b0111;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (s_axis_tready !== 4'b0010) begin
                fails++; $display("FAIL mask_tready k=%0d got %b want 0010", k, s_axis_tready);
            end
            tick;
            tests++;
            if (m_axis_tid !== 2'd1) begin
                fails++; $display("FAIL mask_tid k=%0d got %0d want 1", k, m_axis_tid);
            end
        end
        s_axis_tvalid = 4'h0;
        src_enable    = 4'hF;
        tick;
        s_axis_tvalid = 4'b0001;
        s_axis_tdata[0*DW +: DW] = 32'h55;
        m_axis_tready = 1'b0;
        tick;
        s_axis_tvalid = 4'h0;
        src_enable    = 4'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests++;
            if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'h55}) begin
                fails++;
                $display("FAIL mask_held k=%0d got v=%0b d=%h want v=1 d=55", k, m_axis_tvalid, m_axis_tdata);
            end
            tick;
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        tests++;
        if ((monitor_tvalid && monitor_tready) !== 1'b1) begin
            fails++; $display("FAIL mask_release got hs=%0b want 1", monitor_tvalid && monitor_tready);
        end
        tick;
        src_enable = 4'hF;
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++; $display("FAIL mask_drain got tvalid=%0b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_reset_mid;
        s_axis_tvalid = 4'b0010;
        s_axis_tdata[1*DW +: DW] = 32'hDEAD;
        m_axis_tready = 1'b0;
        tick;
        tests++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'hDEAD}) begin
            fails++; $display("FAIL rmid_load got v=%0b d=%h want v=1 d=dead", m_axis_tvalid, m_axis_tdata);
        end
        reset         = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        tests++;
        if (s_axis_tready !== 4'b0000) begin
            fails++; $display("FAIL rmid_tready got %b want 0000", s_axis_tready);
        end
        tick;
        tests++;
        if ({m_axis_tvalid, m_axis_tdata, dut.rr_ptr} !== {1'b1 ^ 1'b1, 32'h0, 2'd0}) begin
            fails++;
            $display("FAIL rmid_after got v=%0b d=%h ptr=%0d want v=0 d=0 ptr=0",
                     m_axis_tvalid, m_axis_tdata, dut.rr_ptr);
        end
        reset         = 1'b0;
        s_axis_tvalid = 4'h0;
    endtask

    task automatic test_fairness;
        logic got;
        got = 1'b0;
        s_axis_tvalid = 4'b0011;
        s_axis_tdata[0*DW +: DW] = 32'hC0;
        s_axis_tdata[1*DW +: DW] = 32'hC1;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (s_axis_tready[1]) got = 1'b1;
            tick;
            if (got) s_axis_tvalid[1] = 1'b0;
        end
        tests++;
        if (got !== 1'b1) begin
            fails++; $display("FAIL fair_src1 got granted=%0b want 1", got);
        end
        s_axis_tvalid = 4'h0;
        tick;
        tick;
    endtask

    task automatic test_random;
        logic [33:0] q[$];
        logic [33:0] e;
        logic [3:0]  acc;
        int issued, hs, cyc, bad_oh;
        issued = 0; hs = 0; cyc = 0; bad_oh = 0;
        acc = 4'h0;
        src_enable    = 4'hF;
        s_axis_tvalid = 4'h0;
        while (hs < 100 && cyc < 5000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) s_axis_tvalid[i] = 1'b0;
                if (!s_axis_tvalid[i] && issued < 100 && $urandom_range(0, 1) == 1) begin
                    s_axis_tvalid[i] = 1'b1;
                    s_axis_tdata[i*DW +: DW] = 32'hB000_0000 + 32'(issued);
                    issued++;
                end
            end
            @(negedge clk);
            if (!$onehot0(s_axis_tready)) bad_oh++;
            if (monitor_tvalid && monitor_tready) begin
                hs++;
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_order got id=%0d d=%h want none", m_axis_tid, m_axis_tdata);
                end else begin
                    e = q.pop_front();
                    if ({m_axis_tid, m_axis_tdata} !== e) begin
                        fails++;
                        $display("FAIL rand_order got id=%0d d=%h want id=%0d d=%h",
                                 m_axis_tid, m_axis_tdata, e[33:32], e[31:0]);
                    end
                end
            end
            acc = s_axis_tready & s_axis_tvalid;
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) q.push_back({2'(i), s_axis_tdata[i*DW +: DW]});
            end
            tick;
            cyc++;
        end
        tests++;
        if (hs !== 100) begin
            fails++; $display("FAIL rand_count got %0d want 100", hs);
        end
        tests++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL rand_leftover got %0d want 0", q.size());
        end
        tests++;
        if (bad_oh !== 0) begin
            fails++; $display("FAIL rand_onehot got %0d want 0", bad_oh);
        end
        s_axis_tvalid = 4'h0;
        m_axis_tready = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        src_enable    = '0;
        m_axis_tready = 1'b0;
        test_reset;
        test_round_robin;
        test_backpressure;
        test_enable_mask;
        test_reset_mid;
        test_fairness;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of AXI4-Stream source ports.
REQ-002 Parameter DATA_W, default 32: tdata width of every source and of the master port.
REQ-003 Port clk  input  1: single clock; all logic on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port s_axis_tdata  input  NUM_SRC*DATA_W: packed source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-006 Port s_axis_tvalid  input  NUM_SRC: per-source valid.
REQ-007 Port s_axis_tready  output  NUM_SRC: per-source ready; at most one bit high in any cycle.
REQ-008 Port src_enable  input  NUM_SRC: per-source enable mask; a disabled source is never granted.
REQ-009 Port m_axis_tdata  output  DATA_W: granted beat's data, registered.
REQ-010 Port m_axis_tid  output  clog2(NUM_SRC): index of the source that produced the current output beat.
REQ-011 Port m_axis_tvalid  output  1: output beat valid, registered.
REQ-012 Port m_axis_tready  input  1: downstream (UART TX path) ready.
REQ-013 Port monitor_tvalid  output  1: copy of m_axis_tvalid, for the transaction monitor.
REQ-014 Port monitor_tready  output  1: copy of m_axis_tready, for the transaction monitor.

Function
REQ-015 The block shall transfer single-beat transactions only; there is no tlast and no packet locking.
REQ-016 The FSM shall have two states: EMPTY (output register empty, m_axis_tvalid=0) and FULL (beat held, m_axis_tvalid=1).
REQ-017 load_en shall be 1 in EMPTY, and 1 in FULL when m_axis_tready=1; otherwise 0.
REQ-018 Candidate set = s_axis_tvalid & src_enable; the selection shall be the first candidate at or after rr_ptr, searching upward modulo NUM_SRC.
REQ-019 s_axis_tready[i] shall be 1 only when load_en=1, a candidate exists, and i is the selected index; it is combinational from s_axis_tvalid, src_enable, m_axis_tready and state.
REQ-020 On an accept (load_en and a candidate exists), the block shall capture m_axis_tdata and m_axis_tid on the next edge, set rr_ptr to (selected+1) mod NUM_SRC, and enter or stay in FULL.
REQ-021 In FULL with m_axis_tready=1 and no candidate, the block shall go to EMPTY and deassert m_axis_tvalid on the next edge.
REQ-022 In FULL with m_axis_tready=0, m_axis_tdata, m_axis_tid and state shall hold, and all s_axis_tready bits shall be 0.
REQ-023 Latency from source handshake to m_axis_tvalid=1 shall be 1 cycle; back-to-back beats shall sustain 1 beat/cycle while m_axis_tready=1.
REQ-024 rr_ptr shall not change in any cycle without an accept.
REQ-025 Clearing a src_enable bit shall never drop a beat already in the output register.
REQ-026 monitor_tvalid and monitor_tready shall be pure wires, so a monitor handshake equals exactly one m_axis handshake.

Reset
REQ-027 On reset the block shall set state=EMPTY, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0 and rr_ptr=0.
REQ-028 Reset mid-transfer shall discard any held beat without raising any s_axis_tready during the reset cycle.

Structure
REQ-029 Shared package axis_arb_pkg shall hold NUM_SRC, DATA_W, ID_W (clog2 NUM_SRC) and the state enum {EMPTY, FULL}.
REQ-030 Sub-module rr_picker shall be purely combinational: inputs request vector and rr_ptr; outputs sel_valid and sel_idx.

Verification
REQ-031 All four sources valid with data 0xA0..0xA3 and m_axis_tready=1 -> output ids 0,1,2,3,0,... one per cycle; each s_axis_tready is one-hot.
REQ-032 Source 2 only, data 0x1234, m_axis_tready=0 for 5 cycles -> m_axis_tvalid=1 and tdata=0x1234 held 5 cycles; s_axis_tready=0 throughout; one handshake once tready=1.
REQ-033 Sources 1 and 3 valid, src_enable=4'b0111 -> only source 1 granted; source 3 tready stays 0.
REQ-034 Reset asserted while in FULL with tdata=0xDEAD -> next cycle m_axis_tvalid=0, tdata=0, rr_ptr=0.
REQ-035 100 random-valid beats with random m_axis_tready -> handshake count on monitor_tvalid&&monitor_tready equals 100, and the beat order per source is preserved.
REQ-036 Source 0 continuously valid and source 1 valid once -> source 1 is granted within 2 accepts (no starvation).
